// File: rtl/bus_cycle_master.sv
// bus_cycle_master
//   Upstream master for the 20-bit address / 8-bit data system bus.
//   Turns a valid/ready request into a T1-T2-T3-[TW]-T4 bus cycle. Wait
//   states are inserted while READY is low, and the cycle is aborted with
//   an error after MAX_WAIT consecutive wait states.
// Ports
//   CLK, RESET            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; accept on posedge when both high
//   req_write, req_io     1=write / 1=I/O cycle
//   req_addr, req_wdata   cycle address and write data
//   rsp_valid             one-cycle completion pulse (during T4)
//   rsp_rdata, rsp_err    read data (00 for writes/aborts), timeout flag
//   ALE, IOM, RD, WR      bus control (RD/WR active low)
//   Address, Data         bus address (held T1..T4), bidirectional data
//   READY                 slave ready, sampled at the end of T3/TW
module bus_cycle_master #(
  parameter int MAX_WAIT = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_io,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        ALE,
  output logic        IOM,
  output logic        RD,
  output logic        WR,
  output logic [19:0] Address,
  inout  wire  [7:0]  Data,
  input  logic        READY
);

  localparam logic [7:0] LP_MAX = 8'(MAX_WAIT);

  typedef enum logic [2:0] {S_TI, S_T1, S_T2, S_T3, S_TW, S_T4} state_t;

  state_t      r_state;
  logic        r_write;
  logic        r_io;
  logic [19:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_wcnt;
  logic        r_ale;
  logic        r_rd_n;
  logic        r_wr_n;
  logic        r_oe;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [7:0]  r_rsp_rdata;

  logic w_accept;
  logic w_done;
  logic w_abort;

  // Ready only in idle and in T4, so a request can chain straight into T1.
  assign req_ready = ~RESET & ((r_state == S_TI) | (r_state == S_T4));
  assign w_accept  = req_valid & req_ready;

  // Cycle ends on READY, or on a timeout once the wait counter saturates.
  assign w_abort = (r_state == S_TW) & ~READY & (r_wcnt == LP_MAX);
  assign w_done  = ((r_state == S_T3) | (r_state == S_TW)) & (READY | w_abort);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= S_TI;
      r_write     <= 1'b0;
      r_io        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wcnt      <= '0;
      r_ale       <= 1'b0;
      r_rd_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_oe        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_TI, S_T4: begin
          if (w_accept) begin
            r_write <= req_write;
            r_io    <= req_io;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wcnt  <= '0;
            r_ale   <= 1'b1;
            r_state <= S_T1;
          end else begin
            r_state <= S_TI;
          end
        end
        S_T1: begin
          r_ale   <= 1'b0;
          r_rd_n  <= r_write;
          r_wr_n  <= ~r_write;
          r_oe    <= r_write;
          r_state <= S_T2;
        end
        S_T2: r_state <= S_T3;
        S_T3, S_TW: begin
          if (w_done) begin
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_oe        <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_abort;
            r_rsp_rdata <= (w_abort | r_write) ? 8'h00 : Data;
            r_state     <= S_T4;
          end else begin
            r_wcnt  <= (r_state == S_T3) ? 8'd1 : r_wcnt + 8'd1;
            r_state <= S_TW;
          end
        end
        default: r_state <= S_TI;
      endcase
    end
  end

  assign ALE       = r_ale;
  assign IOM       = r_io;
  assign RD        = r_rd_n;
  assign WR        = r_wr_n;
  assign Address   = r_addr;
  assign Data      = r_oe ? r_wdata : 8'hzz;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_bus_cycle_master.sv
module tb_bus_cycle_master;
  localparam int MW = 3;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_valid, req_ready, req_write, req_io;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic        ALE, IOM, RD, WR;
  logic [19:0] Address;
  wire  [7:0]  Data;
  logic        READY;

  int n_chk = 0;
  int n_bad = 0;

  bus_cycle_master #(.MAX_WAIT(MW)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR), .Address(Address),
    .Data(Data), .READY(READY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] init_val(int i);
    return (i == 16) ? 8'hA5 : 8'(i * 29 + 7);
  endfunction

  // Bus slave standing in for memory_1: 256 bytes, aliased on Address[7:0].
  logic [7:0] mem [256];
  logic       w_mem_oe;
  logic [7:0] w_mem_q;
  assign w_mem_oe = ~RD & ~IOM & ~Address[19];
  assign w_mem_q  = mem[Address[7:0]];
  assign Data     = w_mem_oe ? w_mem_q : 8'hzz;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    forever begin
      @(posedge CLK);
      if (!WR && !IOM && !Address[19]) mem[Address[7:0]] <= Data;
    end
  end

  // Reference model: expected memory contents as seen by the requester.
  logic [7:0] ref_mem [256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after a negedge with the bus idle; returns just after a negedge.
  task automatic do_cycle(input bit wr, input logic [19:0] a, input logic [7:0] d, input int nlow);
    int exp_len;
    bit exp_err;
    logic [7:0] exp_rd;
    int w;
    exp_err = (nlow > MW);
    exp_len = exp_err ? 3 + MW : 3 + nlow;
    exp_rd  = (wr || exp_err) ? 8'h00 : ref_mem[a[7:0]];
    req_valid = 1'b1; req_write = wr; req_io = 1'b0; req_addr = a; req_wdata = d;
    READY = 1'b0;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge CLK); w++; end
    if (!req_ready) begin
      chk("ready_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge CLK); #1;
    // Scramble request inputs after acceptance; the cycle must not notice.
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = 20'($urandom);
    req_wdata = 8'($urandom);
    @(negedge CLK);
    for (int c = 0; c <= exp_len; c++) begin
      chk("addr", Address, a);
      chk("iom", IOM, 0);
      chk("ale", ALE, (c == 0));
      if (c >= 1 && c < exp_len) begin
        chk("rd", RD, wr);
        chk("wr", WR, !wr);
        if (wr) chk("wdata", Data, d);
      end else begin
        chk("rd_idle", RD, 1);
        chk("wr_idle", WR, 1);
      end
      chk("rsp_valid", rsp_valid, (c == exp_len));
      if (c == exp_len) begin
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("ready_t4", req_ready, 1);
      end
      READY = (c >= 2) ? ((c - 2) >= nlow) : 1'b0;
      @(negedge CLK);
    end
    chk("rsp_after", rsp_valid, 0);
    chk("ale_after", ALE, 0);
    if (wr && !exp_err) ref_mem[a[7:0]] = d;
  endtask

  task automatic back_to_back();
    logic [19:0] adr [3];
    int rt[$];
    logic [7:0] rd[$];
    int k;
    bit acc;
    for (int i = 0; i < 3; i++) adr[i] = 20'($urandom_range(0, 255));
    k = 0;
    READY = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_io = 1'b0; req_addr = adr[0]; req_wdata = 8'h00;
    for (int c = 0; c < 20; c++) begin
      acc = req_ready && req_valid;
      if (rsp_valid) begin rt.push_back(c); rd.push_back(rsp_rdata); end
      @(posedge CLK); #1;
      if (acc) begin
        k++;
        if (k < 3) req_addr = adr[k];
        else req_valid = 1'b0;
      end
      @(negedge CLK);
    end
    chk("b2b_count", rt.size(), 3);
    if (rt.size() == 3) begin
      chk("b2b_first", rt[0], 4);
      chk("b2b_gap1", rt[1] - rt[0], 4);
      chk("b2b_gap2", rt[2] - rt[1], 4);
      for (int i = 0; i < 3; i++) chk("b2b_rdata", rd[i], ref_mem[adr[i][7:0]]);
    end
  endtask

  task automatic reset_mid_cycle();
    int seen;
    READY = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_io = 1'b0; req_addr = 20'h00044;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(negedge CLK);          // T1
    @(negedge CLK);          // T2
    chk("mid_rd_t2", RD, 0);
    RESET = 1'b1;
    @(negedge CLK);
    chk("mid_ale", ALE, 0);
    chk("mid_rd", RD, 1);
    chk("mid_wr", WR, 1);
    chk("mid_ready_rst", req_ready, 0);
    chk("mid_rsp", rsp_valid, 0);
    RESET = 1'b0;
    #1;
    chk("mid_ready_ti", req_ready, 1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen++;
      @(negedge CLK);
    end
    chk("mid_no_rsp", seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    RESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0;
    req_addr = '0; req_wdata = '0; READY = 1'b1;
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK);
    chk("rst_ale", ALE, 0);
    chk("rst_rd", RD, 1);
    chk("rst_wr", WR, 1);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_addr", Address, 0);
    chk("rst_iom", IOM, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    RESET = 1'b0;
    @(negedge CLK);
    chk("ready_ti", req_ready, 1);

    do_cycle(1'b0, 20'h00010, 8'h00, 0);     // preloaded A5
    do_cycle(1'b1, 20'h00020, 8'h3C, 0);
    do_cycle(1'b0, 20'h00020, 8'h00, 0);
    back_to_back();
    do_cycle(1'b0, 20'h00031, 8'h00, 2);     // two wait states
    do_cycle(1'b0, 20'h00032, 8'h00, MW);    // last wait before timeout
    do_cycle(1'b0, 20'h00033, 8'h00, 9);     // READY stuck low -> abort
    do_cycle(1'b1, 20'h00034, 8'h77, 9);     // aborted write
    do_cycle(1'b0, 20'h00010, 8'h00, 0);
    reset_mid_cycle();

    for (int t = 0; t < 40; t++) begin
      bit wr;
      int nl;
      wr = 1'($urandom);
      nl = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 6));
      do_cycle(wr, 20'($urandom_range(0, 255)), 8'($urandom), nl);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
